// File: rtl/muldiv4_if.sv
// Requester-facing bus of muldiv4_arbiter: two op request channels and two result channels.
interface muldiv4_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_muldiv;
  logic [1:0]  req_signed;
  logic [15:0] req_opnd;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_eover;
  logic        rsp_ediv0;
  logic        busy;

  modport master (
    output req_valid, req_muldiv, req_signed, req_opnd, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_eover, rsp_ediv0, busy
  );

  modport slave (
    input  req_valid, req_muldiv, req_signed, req_opnd, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_eover, rsp_ediv0, busy
  );
endinterface

// File: rtl/muldiv4.sv
// Shared 4-bit multiplier/divider with round-robin arbitration between two requesters.
// Contains the combinational mul4/div4 pair and the arbiter that time-shares them.

module mul4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       signed_i,
  output logic [7:0] p_o
);
  logic [7:0] ax, bx;

  // Low 8 bits of the extended product are correct for both signednesses
  always_comb begin
    ax  = signed_i ? {{4{a_i[3]}}, a_i} : {4'b0000, a_i};
    bx  = signed_i ? {{4{b_i[3]}}, b_i} : {4'b0000, b_i};
    p_o = ax * bx;
  end
endmodule

module div4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       signed_i,
  output logic [3:0] q_o,
  output logic [3:0] r_o,
  output logic       eover_o,
  output logic       ediv0_o
);
  logic       neg_a, neg_b;
  logic [4:0] ma, mb, mb_safe, mq, mr;
  logic [3:0] qs, rs;

  // Magnitude division; quotient truncates toward zero, remainder takes the dividend's sign
  always_comb begin
    neg_a   = signed_i & a_i[3];
    neg_b   = signed_i & b_i[3];
    ma      = neg_a ? 5'(5'd0 - {1'b1, a_i}) : {1'b0, a_i};
    mb      = neg_b ? 5'(5'd0 - {1'b1, b_i}) : {1'b0, b_i};
    mb_safe = (b_i == 4'd0) ? 5'd1 : mb;
    mq      = ma / mb_safe;
    mr      = ma % mb_safe;
    qs      = (neg_a ^ neg_b) ? 4'(5'd0 - mq) : mq[3:0];
    rs      = neg_a ? 4'(5'd0 - mr) : mr[3:0];
    ediv0_o = (b_i == 4'd0);
    eover_o = signed_i & (a_i == 4'h8) & (b_i == 4'hF);
    // Divide by zero yields all-ones quotient and the dividend as remainder
    q_o     = ediv0_o ? 4'hF : qs;
    r_o     = ediv0_o ? a_i  : rs;
  end
endmodule

module muldiv4_arbiter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv4_if.slave bus
);
  if (WIDTH != 4) begin : g_width_err
    $error("muldiv4_arbiter: WIDTH must be 4");
  end
  if (SETTLE == 0) begin : g_settle_err
    $error("muldiv4_arbiter: SETTLE must be at least 1");
  end

  localparam int unsigned CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       a_q, a_d, b_q, b_d;
  logic             div_q, div_d, sgn_q, sgn_d, id_q, id_d;
  logic [7:0]       data_q, data_d;
  logic             eover_q, eover_d, ediv0_q, ediv0_d;
  logic [1:0]       rsp_valid_q, rsp_valid_d;

  logic             gnt_c;
  logic [1:0]       req_ready_c;
  logic [7:0]       prod;
  logic [3:0]       quo, rem;
  logic             eover_c, ediv0_c;

  mul4 u_mul4 (.a_i(a_q), .b_i(b_q), .signed_i(sgn_q), .p_o(prod));
  div4 u_div4 (.a_i(a_q), .b_i(b_q), .signed_i(sgn_q), .q_o(quo), .r_o(rem),
               .eover_o(eover_c), .ediv0_o(ediv0_c));

  // Round-robin grant; ready is only offered in IDLE and never while reset is asserted
  always_comb begin
    gnt_c       = 1'b0;
    req_ready_c = 2'b00;
    case (bus.req_valid)
      2'b01:   gnt_c = 1'b0;
      2'b10:   gnt_c = 1'b1;
      2'b11:   gnt_c = ~last_q;
      default: gnt_c = 1'b0;
    endcase
    if (state_q == IDLE && rst_n && bus.req_valid[gnt_c]) begin
      req_ready_c[gnt_c] = 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    div_d       = div_q;
    sgn_d       = sgn_q;
    id_d        = id_q;
    data_d      = data_q;
    eover_d     = eover_q;
    ediv0_d     = ediv0_q;
    rsp_valid_d = rsp_valid_q;
    case (state_q)
      IDLE: begin
        if (req_ready_c != 2'b00) begin
          state_d = EXEC;
          id_d    = gnt_c;
          a_d     = gnt_c ? bus.req_opnd[11:8]  : bus.req_opnd[3:0];
          b_d     = gnt_c ? bus.req_opnd[15:12] : bus.req_opnd[7:4];
          div_d   = bus.req_muldiv[gnt_c];
          sgn_d   = bus.req_signed[gnt_c];
          cnt_d   = CNT_W'(SETTLE - 1);
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          data_d      = div_q ? {rem, quo} : prod;
          eover_d     = div_q & eover_c;
          ediv0_d     = div_q & ediv0_c;
          rsp_valid_d = id_q ? 2'b10 : 2'b01;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (bus.rsp_ready[id_q]) begin
          state_d     = IDLE;
          last_d      = id_q;
          rsp_valid_d = 2'b00;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      div_q       <= 1'b0;
      sgn_q       <= 1'b0;
      id_q        <= 1'b0;
      data_q      <= '0;
      eover_q     <= 1'b0;
      ediv0_q     <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      div_q       <= div_d;
      sgn_q       <= sgn_d;
      id_q        <= id_d;
      data_q      <= data_d;
      eover_q     <= eover_d;
      ediv0_q     <= ediv0_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign bus.req_ready = req_ready_c;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_eover = eover_q;
  assign bus.rsp_ediv0 = ediv0_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_muldiv4_arbiter.sv
// Bench for muldiv4_arbiter: directed ops with literal expectations plus a cycle-level
// transaction model that checks every output on every falling edge.
module tb_muldiv4_arbiter;
  localparam int unsigned SETTLE = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv4_if bus ();
  muldiv4_arbiter #(.WIDTH(4), .SETTLE(SETTLE)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference: integer mul/div with truncating division
  function automatic void model_op(input logic div, input logic sgn, input logic [3:0] a,
                                   input logic [3:0] b, output logic [7:0] d,
                                   output logic eo, output logic e0, output logic known);
    int sa, sb, q, r;
    logic signed [3:0] ta, tb4;
    ta = a;
    tb4 = b;
    sa = sgn ? int'(ta) : int'(a);
    sb = sgn ? int'(tb4) : int'(b);
    d = 8'h00; eo = 1'b0; e0 = 1'b0; known = 1'b1;
    if (!div) begin
      q = sa * sb;
      d = q[7:0];
    end else if (sb == 0) begin
      e0 = 1'b1; known = 1'b0;
    end else if (sgn && sa == -8 && sb == -1) begin
      eo = 1'b1; known = 1'b0;
    end else begin
      q = sa / sb;
      r = sa % sb;
      d = {r[3:0], q[3:0]};
    end
  endfunction

  // Transaction model state
  bit         m_busy = 1'b0;
  bit         m_owner = 1'b0;
  bit         m_last = 1'b1;
  int         m_age = 0;
  logic [7:0] m_d;
  logic       m_eo, m_e0, m_known;
  logic [1:0] cv, cer;
  bit         cg;

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_rsp_data", bus.rsp_data, 0);
      chk("rst_flags", {bus.rsp_eover, bus.rsp_ediv0}, 0);
      m_busy = 1'b0;
      m_last = 1'b1;
    end else if (!m_busy) begin
      cv  = bus.req_valid;
      cer = 2'b00;
      cg  = (cv == 2'b11) ? !m_last : cv[1];
      if (cv != 2'b00) cer[cg] = 1'b1;
      chk("m_req_ready", bus.req_ready, cer);
      chk("m_rsp_valid_idle", bus.rsp_valid, 0);
      chk("m_busy_idle", bus.busy, 0);
      if (cer != 2'b00) begin
        m_busy  = 1'b1;
        m_owner = cg;
        m_age   = 0;
        model_op(bus.req_muldiv[cg], bus.req_signed[cg],
                 cg ? bus.req_opnd[11:8] : bus.req_opnd[3:0],
                 cg ? bus.req_opnd[15:12] : bus.req_opnd[7:4],
                 m_d, m_eo, m_e0, m_known);
      end
    end else begin
      m_age++;
      chk("m_req_ready_busy", bus.req_ready, 0);
      chk("m_busy", bus.busy, 1);
      if (m_age <= int'(SETTLE)) begin
        chk("m_rsp_valid_exec", bus.rsp_valid, 0);
      end else begin
        chk("m_rsp_valid", bus.rsp_valid, m_owner ? 2'b10 : 2'b01);
        if (m_known) chk("m_rsp_data", bus.rsp_data, m_d);
        chk("m_eover", bus.rsp_eover, m_eo);
        chk("m_ediv0", bus.rsp_ediv0, m_e0);
        if (bus.rsp_ready[m_owner]) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end
  end

  task automatic set_req(input int id, input logic div, input logic sgn,
                         input logic [3:0] a, input logic [3:0] b);
    bus.req_valid[id]  = 1'b1;
    bus.req_muldiv[id] = div;
    bus.req_signed[id] = sgn;
    if (id == 0) bus.req_opnd[7:0] = {b, a};
    else         bus.req_opnd[15:8] = {b, a};
  endtask

  // Returns after the accepting edge (+1)
  task automatic wait_grant(output int who);
    who = -1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (bus.req_ready != 2'b00) begin
        who = bus.req_ready[1] ? 1 : 0;
        break;
      end
    end
    if (who < 0) chk("grant_timeout", 1, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int id, output int lat);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (bus.rsp_valid[id]) break;
    end
  endtask

  task automatic ack(input int id);
    @(posedge clk); #1;
    bus.rsp_ready[id] = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready[id] = 1'b0;
  endtask

  task automatic do_op(input int id, input logic div, input logic sgn, input logic [3:0] a,
                       input logic [3:0] b, input logic [7:0] exp_d, input bit chk_d,
                       input logic exp_eo, input logic exp_e0);
    int who, lat;
    set_req(id, div, sgn, a, b);
    wait_grant(who);
    chk("grant", 16'(who), 16'(id));
    bus.req_valid[id] = 1'b0;
    bus.req_opnd = ~bus.req_opnd;
    wait_rsp(id, lat);
    chk("latency", 16'(lat), 16'(SETTLE + 1));
    if (chk_d) chk("rsp_data", bus.rsp_data, exp_d);
    chk("rsp_eover", bus.rsp_eover, exp_eo);
    chk("rsp_ediv0", bus.rsp_ediv0, exp_e0);
    ack(id);
    chk("busy_after_ack", bus.busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int who, lat;
    int order[4];
    bus.req_valid = 2'b00; bus.req_muldiv = 2'b00; bus.req_signed = 2'b00;
    bus.req_opnd = 16'h0000; bus.rsp_ready = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    do_op(0, 1'b0, 1'b0, 4'd3, 4'd5, 8'h0F, 1'b1, 1'b0, 1'b0);
    do_op(1, 1'b0, 1'b1, 4'hE, 4'd3, 8'hFA, 1'b1, 1'b0, 1'b0);
    do_op(1, 1'b1, 1'b0, 4'd13, 4'd4, 8'h13, 1'b1, 1'b0, 1'b0);
    do_op(0, 1'b1, 1'b1, 4'h8, 4'hF, 8'h00, 1'b0, 1'b1, 1'b0);
    do_op(0, 1'b1, 1'b0, 4'd7, 4'd0, 8'h00, 1'b0, 1'b0, 1'b1);
    do_op(1, 1'b1, 1'b1, 4'h9, 4'd2, 8'hFD, 1'b1, 1'b0, 1'b0);
    do_op(0, 1'b0, 1'b0, 4'hF, 4'hF, 8'hE1, 1'b1, 1'b0, 1'b0);

    // Arbitration from reset with both requesters always valid
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 1'b0, 1'b0, 4'd1, 4'd2);
    set_req(1, 1'b0, 1'b0, 4'd3, 4'd4);
    for (int k = 0; k < 4; k++) begin
      wait_grant(who);
      order[k] = who;
      wait_rsp(who, lat);
      chk("arb_rsp_data", bus.rsp_data, (who == 0) ? 16'h02 : 16'h0C);
      ack(who);
    end
    bus.req_valid = 2'b00;
    for (int k = 0; k < 4; k++) chk("arb_order", 16'(order[k]), 16'(k % 2));

    // Only requester 1 valid: served back-to-back
    set_req(1, 1'b0, 1'b0, 4'd2, 4'd3);
    for (int k = 0; k < 2; k++) begin
      wait_grant(who);
      chk("solo_grant", 16'(who), 16'd1);
      wait_rsp(1, lat);
      chk("solo_latency", 16'(lat), 16'(SETTLE + 1));
      ack(1);
    end
    bus.req_valid = 2'b00;

    // Backpressure with non-owner ready asserted and a pending request
    set_req(0, 1'b0, 1'b0, 4'd6, 4'd7);
    wait_grant(who);
    bus.req_valid[0] = 1'b0;
    wait_rsp(0, lat);
    @(posedge clk); #1;
    bus.rsp_ready[1] = 1'b1;
    set_req(1, 1'b0, 1'b0, 4'd2, 4'd2);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_rsp_valid", bus.rsp_valid, 2'b01);
      chk("bp_rsp_data", bus.rsp_data, 8'h2A);
      chk("bp_req_ready", bus.req_ready, 2'b00);
      chk("bp_busy", bus.busy, 1);
    end
    @(posedge clk); #1;
    bus.rsp_ready[1] = 1'b0;
    ack(0);
    wait_grant(who);
    chk("bp_next_grant", 16'(who), 16'd1);
    bus.req_valid = 2'b00;
    wait_rsp(1, lat);
    chk("bp_next_data", bus.rsp_data, 8'h04);
    ack(1);

    // Reset during EXEC abandons the op
    set_req(0, 1'b0, 1'b0, 4'd5, 4'd5);
    wait_grant(who);
    set_req(1, 1'b0, 1'b0, 4'd1, 4'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_ready", bus.req_ready, 2'b00);
    chk("arst_rsp_valid", bus.rsp_valid, 2'b00);
    chk("arst_busy", bus.busy, 0);
    chk("arst_rsp_data", bus.rsp_data, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_grant(who);
    chk("post_rst_grant", 16'(who), 16'd0);
    bus.req_valid = 2'b00;
    wait_rsp(0, lat);
    chk("post_rst_latency", 16'(lat), 16'(SETTLE + 1));
    chk("post_rst_data", bus.rsp_data, 8'h19);
    ack(0);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
